// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer (IF/ID/EX/MEM/WB); PERF_CNT_EN adds cycle/instret counters
module multicycle_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       ir_we,
  input  logic       is_load,
  input  logic       is_store,
  input  logic       is_halt,
  input  logic       reg_we_dec,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       rf_we,
  output logic       pc_we,
  output logic [2:0] stage,
  output logic       halted,
  output logic       err
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);
  typedef enum logic [2:0] {S_RST, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_ERR} state_t;
  localparam int W = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [W-1:0] LAST = W'(MAX_WAIT > 0 ? MAX_WAIT - 1 : 0);
  state_t state, nxt;
  logic [W-1:0] wcnt;
  logic waiting, timeout;
  assign waiting = (state == S_IF && !imem_ready) || (state == S_MEM && !dmem_ready);
  assign timeout = MAX_WAIT > 0 && waiting && wcnt == LAST;
  // state register and consecutive not-ready counter; counter is zero whenever not stalling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
      wcnt  <= '0;
    end else begin
      state <= nxt;
      wcnt  <= waiting ? wcnt + 1'b1 : '0;
    end
  end
  // next state and combinational output decode
  always_comb begin
    nxt      = state;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    case (state)
      S_RST: nxt = S_IF;
      S_IF: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
        nxt      = imem_ready ? S_ID : timeout ? S_ERR : S_IF;
      end
      S_ID: nxt = is_halt ? S_HALT : S_EX;
      S_EX: nxt = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        nxt      = dmem_ready ? S_WB : timeout ? S_ERR : S_MEM;
      end
      S_WB: begin
        pc_we = 1'b1;
        rf_we = reg_we_dec & ~is_store;
        nxt   = S_IF;
      end
      S_HALT: halted = 1'b1;
      default: begin
        halted = 1'b1;
        err    = 1'b1;
      end
    endcase
  end
  assign stage = state;
`ifdef PERF_CNT_EN
  // cycles spent running instructions and retired instruction count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (!(state inside {S_RST, S_HALT, S_ERR})) cycle_cnt <= cycle_cnt + 32'd1;
      if (state == S_WB) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and generates the enables for the IR latch, register file, PC and data memory. It consumes the decoder's classification flags and drives both memory request handshakes. It sits between the instruction/data memory interfaces and the decoder/ALU/regfile datapath.

Parameters:
MAX_WAIT, 255, consecutive not-ready cycles tolerated on either memory handshake before the error state; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request
imem_ready  in  1  instruction word valid this cycle
ir_we  out  1  latch the fetched word into IR
is_load  in  1  decoder flag, load instruction
is_store  in  1  decoder flag, store instruction
is_halt  in  1  decoder flag, halt instruction
reg_we_dec  in  1  decoder register-write flag
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
dmem_ready  in  1  data access complete this cycle
rf_we  out  1  register file write enable
pc_we  out  1  PC update enable
stage  out  3  current state encoding
halted  out  1  core stopped (halt or error)
err  out  1  memory timeout occurred

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low. Only the state register and wait counter are flopped; all outputs are decoded combinationally from the state plus the ready/flag inputs.
- State encoding on stage: RST=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6, ERR=7.
- Reset: state=RST and wait counter=0. All outputs are 0 while rst_n is low and in RST, with stage=0. Reset asserted mid-operation aborts immediately; dmem_req and imem_req drop with rst_n.
- RST: unconditional transition to IF on the next edge.
- IF: imem_req=1. ir_we = imem_ready. On imem_ready, go to ID.
- ID: one cycle. Decoder flags are sampled here. If is_halt, go to HALT with no pc_we; otherwise go to EX.
- EX: one cycle. If is_load or is_store, go to MEM; otherwise go to WB.
- MEM: dmem_req=1 and dmem_we=is_store, both held stable until dmem_ready. On dmem_ready, go to WB.
- WB: pc_we=1 and rf_we = reg_we_dec & ~is_store. Then go to IF.
- HALT: halted=1. Sticky until reset; all requests stay low.
- ERR: halted=1 and err=1. Sticky until reset.
- Wait counter: width clog2(MAX_WAIT+1). Cleared on entry to IF or MEM. Increments on each cycle in IF/MEM with the ready input low. When MAX_WAIT>0 and the counter reaches MAX_WAIT (i.e. MAX_WAIT consecutive not-ready cycles), the next state is ERR. Ready arriving in the same cycle the counter would reach MAX_WAIT counts as a success.
- imem_ready and dmem_ready are ignored outside IF and MEM respectively.
- Decoder flags are don't-care outside ID/EX/MEM/WB. They are stable in those states because IR is held.
- Latency with zero-wait memories: 4 cycles for non-memory instructions, 5 for loads/stores. Each wait cycle adds one.
- Every IF..WB pass produces exactly one ir_we pulse and one pc_we pulse.

Optional Feature:
Macro PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0. cycle_cnt increments every cycle while state is not RST/HALT/ERR. instret_cnt increments on each WB cycle. Both wrap modulo 2^32.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ready=1, ALU op with reg_we_dec=1 for 3 instrs -> stage sequence 0,1,2,3,5 repeating; rf_we and pc_we high only in WB; ir_we 3 pulses. With PERF_CNT_EN: cycle_cnt=12 and instret_cnt=3 after the third WB.
- Load, dmem_ready low 3 cycles then high -> dmem_req high 4 cycles, dmem_we=0, rf_we=1 in WB; instruction takes 8 cycles.
- Store with reg_we_dec=1, dmem_ready=1 -> dmem_we=1 for 1 MEM cycle; WB has rf_we=0, pc_we=1.
- is_halt=1 at ID -> stage=6 and halted=1 on the next cycle with no pc_we; remains so for 100 cycles while imem_ready toggles and imem_req stays 0.
- MAX_WAIT=4, imem_ready held 0 -> imem_req high 4 cycles, then stage=7, err=1, halted=1. Same run with imem_ready rising in the 4th cycle -> enters ID, no error.
- rst_n driven low during MEM of a load -> dmem_req=0 and stage=0 immediately. After release: 1 cycle RST, then IF; no rf_we for the aborted load.
